// File: rtl/dram_burst_model_pkg.sv
// Shared types, default geometry and helpers for the burst DRAM model.
// Modules recompute their own widths from parameters; the values here describe the default build.
package dram_model_pkg;

    localparam int DEFAULT_ADDR_W      = 32;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_LINE_WORDS  = 4;

    localparam int WORD_IDX_W = $clog2(DEFAULT_DEPTH_WORDS);
    localparam int OFF_W      = $clog2(DEFAULT_LINE_WORDS);
    localparam int BYTE_OFF_W = $clog2(DEFAULT_DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_WAIT   = 3'd1,
        RD_BURST  = 3'd2,
        WR_WAIT   = 3'd3,
        WR_COMMIT = 3'd4
    } state_e;

    // Critical-word-first ordering: the offset wraps inside the (power-of-two) line.
    function automatic int unsigned wrap_beat(input int unsigned crit,
                                              input int unsigned beat,
                                              input int unsigned line_words);
        return (crit + beat) & (line_words - 1);
    endfunction

endpackage

// File: rtl/dram_burst_model_if.sv
// Request/response bus between the cache controller (master) and the DRAM model (slave).
interface dram_burst_model_if
    import dram_model_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_we;
    logic [ADDR_W-1:0]            req_addr;
    logic [LINE_WORDS*DATA_W-1:0] req_wdata;
    logic [LINE_WORDS-1:0]        req_wstrb;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATA_W-1:0]            rsp_data;
    logic                         rsp_last;
    logic                         wr_done;
    logic                         busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last, wr_done, busy
    );
endinterface

// File: rtl/dram_burst_model_latency_ctr.sv
// Loadable down-counter with a zero flag, used for both the read and write access latency.
module dram_latency_ctr #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/dram_burst_model.sv
// Cycle-approximate DRAM model serving wrapped line fills and strobed line write-backs.
// Storage is not touched by reset; only the control path returns to IDLE.
module dram_burst_model
    import dram_model_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LINE_WORDS  = DEFAULT_LINE_WORDS,
    parameter int RD_LAT      = 4,
    parameter int WR_LAT      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dram_burst_model_if.slave bus
);
    localparam int WIDX_W  = $clog2(DEPTH_WORDS);
    localparam int LOFF_W  = $clog2(LINE_WORDS);
    localparam int BOFF_W  = $clog2(DATA_W / 8);
    localparam int BEAT_W  = (LOFF_W > 0) ? LOFF_W : 1;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [WIDX_W-1:0] OFF_MASK = WIDX_W'(LINE_WORDS - 1);

    state_e                       state_q, state_d;
    logic                         ready_en_q;
    logic [WIDX_W-1:0]            idx_q;
    logic [LINE_WORDS*DATA_W-1:0] wdata_q;
    logic [LINE_WORDS-1:0]        wstrb_q;
    logic [BEAT_W-1:0]            beat_q, beat_d;

    logic                         ctr_load;
    logic [CNT_W-1:0]             ctr_val;
    logic                         ctr_dec;
    logic                         ctr_zero;

    logic                         req_ready;
    logic                         accept;
    logic                         rsp_valid;
    logic                         rsp_last;
    logic [WIDX_W-1:0]            base_idx;
    logic [WIDX_W-1:0]            rd_idx;
    logic                         unused_addr;

    // Zero at time 0 so fills of never-written lines return defined data.
    logic [DATA_W-1:0]            mem_q [DEPTH_WORDS] = '{default: '0};

    dram_latency_ctr #(.CNT_W(CNT_W)) u_lat_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load),
        .load_val_i (ctr_val),
        .dec_i      (ctr_dec),
        .zero_o     (ctr_zero)
    );

    assign req_ready   = ready_en_q && (state_q == IDLE);
    assign accept      = bus.req_valid && req_ready;
    assign rsp_valid   = (state_q == RD_BURST);
    assign rsp_last    = rsp_valid && (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign base_idx    = idx_q & ~OFF_MASK;
    assign rd_idx      = base_idx | WIDX_W'(wrap_beat(32'(idx_q & OFF_MASK), 32'(beat_q), LINE_WORDS));
    assign unused_addr = ^bus.req_addr;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        ctr_load = 1'b0;
        ctr_val  = '0;
        ctr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ctr_load = 1'b1;
                    beat_d   = '0;
                    if (bus.req_we) begin
                        state_d = WR_WAIT;
                        ctr_val = CNT_W'(WR_LAT - 1);
                    end else begin
                        state_d = RD_WAIT;
                        ctr_val = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            RD_WAIT: begin
                if (ctr_zero) state_d = RD_BURST;
                else          ctr_dec = 1'b1;
            end
            RD_BURST: begin
                if (bus.rsp_ready) begin
                    if (rsp_last) state_d = IDLE;
                    else          beat_d  = beat_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (ctr_zero) state_d = WR_COMMIT;
                else          ctr_dec = 1'b1;
            end
            WR_COMMIT: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ready_en_q keeps req_ready low while reset is held and for no longer than one edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            ready_en_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                idx_q   <= bus.req_addr[BOFF_W +: WIDX_W];
                wdata_q <= bus.req_wdata;
                wstrb_q <= bus.req_wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WR_COMMIT) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                if (wstrb_q[k]) begin
                    mem_q[base_idx | WIDX_W'(k)] <= wdata_q[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_last  = rsp_last;
    assign bus.rsp_data  = rsp_valid ? mem_q[rd_idx] : '0;
    assign bus.wr_done   = (state_q == WR_COMMIT);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/dram_burst_model.md
Name: dram_burst_model

Overview:
- Parametrised, cycle-approximate DRAM behavioural model; successor to the single-word, zero-latency dummy DRAM.
- Sits below the data-cache controller and serves cache-line fills and line write-backs.
- Uses a valid/ready request channel, a programmable access latency, critical-word-first wrapped read bursts with response back-pressure, and per-word write strobes.
- Simulation and FPGA-prototype model only; not a DRAM controller.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH_WORDS, 1024: storage depth in words; power of two.
- LINE_WORDS, 4: words per cache line; power of two, 1 to 16.
- RD_LAT, 4: cycles from read acceptance to the first response beat; at least 1.
- WR_LAT, 2: cycles from write acceptance to commit; at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_we  in  1  0 = line read (fill), 1 = line write (write-back).
- req_addr  in  ADDR_W  byte address of the critical word.
- req_wdata  in  LINE_WORDS*DATA_W  write line; word k occupies bits [k*DATA_W +: DATA_W].
- req_wstrb  in  LINE_WORDS  per-word write enable.
- rsp_valid  out  1  read beat valid.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_data  out  DATA_W  read beat data.
- rsp_last  out  1  final beat of the burst.
- wr_done  out  1  one-cycle pulse when a write commits.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Addressing:
  - word index = req_addr[log2(DATA_W/8) +: log2(DEPTH_WORDS)]; upper address bits are ignored, so addresses alias.
  - line base = word index with its low log2(LINE_WORDS) bits cleared.
  - Byte-offset bits are ignored.
- Storage: array of DEPTH_WORDS x DATA_W, zero-initialised at time 0. rst_n does not clear storage; it resets control logic only.
- FSM states: IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_COMMIT.
- req_ready = 1 only in IDLE. On acceptance, the model latches req_we, the word index, req_wdata and req_wstrb, and loads the latency counter.
  - Read: IDLE -> RD_WAIT with counter = RD_LAT-1.
  - Write: IDLE -> WR_WAIT with counter = WR_LAT-1.
- RD_WAIT: counter decrements each cycle. At 0 the model moves to RD_BURST and presents beat 0. The first beat is therefore visible exactly RD_LAT cycles after the acceptance edge.
- RD_BURST:
  - beat b returns the word at line base + ((critical offset + b) mod LINE_WORDS), i.e. critical word first with wrap inside the line.
  - rsp_valid is held high; rsp_data and rsp_last are stable while rsp_ready is low.
  - Beat advances on rsp_valid & rsp_ready.
  - rsp_last = 1 on beat LINE_WORDS-1; its handshake returns the FSM to IDLE.
  - One beat per cycle while rsp_ready stays high.
- WR_WAIT -> WR_COMMIT when the counter reaches 0.
- WR_COMMIT (one cycle):
  - every word k with wstrb[k]=1 is written at line base + k; words with wstrb[k]=0 are untouched.
  - wr_done = 1 for this cycle; FSM returns to IDLE.
  - wstrb = 0 commits nothing but still pulses wr_done.
- Back-to-back: no new request is accepted in the cycle the FSM leaves RD_BURST or WR_COMMIT. The earliest next acceptance is the following cycle (IDLE).
- Read-after-write: a read accepted after wr_done sees the committed data.
- LINE_WORDS=1: the burst is a single beat with rsp_last = 1.
- Reset, asynchronous on rst_n low, including mid-burst or mid-wait:
  - FSM -> IDLE; counters -> 0.
  - req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, wr_done=0, busy=0.
  - The in-flight request is dropped; a pending write does not commit.
  - req_ready rises in the first cycle after rst_n deasserts.
- busy = (state != IDLE).

Decomposition:
- Package dram_model_pkg holds:
  - typedef of the FSM state enum;
  - localparams WORD_IDX_W = log2(DEPTH_WORDS), OFF_W = log2(LINE_WORDS), BYTE_OFF_W = log2(DATA_W/8);
  - a function computing the wrapped beat index.
- One sub-module, dram_latency_ctr: a loadable down-counter with a zero flag, shared by RD_WAIT and WR_WAIT.
- The storage array stays in the top module.

Test Plan:
- Reset, then read at req_addr=0x0 -> first beat exactly 4 cycles after acceptance; beats 0,0,0,0 on 4 consecutive cycles; rsp_last only on beat 4.
- Write req_addr=0x40, wdata={D,C,B,A}=0xDDDD/0xCCCC/0xBBBB/0xAAAA, wstrb=4'b1111 -> wr_done 2 cycles after acceptance. Then read 0x48 -> beats 0xCCCC, 0xDDDD, 0xAAAA, 0xBBBB (wrapped).
- Write 0x40 with wstrb=4'b0101 and new data 1,2,3,4 -> read 0x40 returns 0x1, 0xBBBB, 0x3, 0xDDDD.
- Read with rsp_ready toggled 1,0,0,1,1,0,1 -> every beat held stable while stalled; 4 beats total, none lost or duplicated; req_ready low until after the last handshake.
- Assert rst_n low during RD_BURST beat 2 -> rsp_valid drops immediately; after release, req_ready=1 and the next read returns correct data. Reset during WR_WAIT -> no wr_done and memory unchanged.
- Read req_addr=0x1040 with DEPTH_WORDS=1024 -> aliases to 0x40 and returns that line's data.
